// File: rtl/io_word_assembler.sv
// Byte-stream to word packer feeding two alternating single-word holding slots.
// Bytes pack little-endian; in_last zero-pads and flushes a partial word.
module io_word_assembler #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic                    ack1,
    input  logic                    ack2,
    output logic                    store1,
    output logic                    store2,
    output logic [8*WORD_BYTES-1:0] data1,
    output logic [8*WORD_BYTES-1:0] data2,
    output logic [15:0]             word_cnt
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int IW = (WORD_BYTES > 2) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WORD_BYTES - 1);
    localparam logic SLOT1 = 1'b0;
    localparam logic SLOT2 = 1'b1;

    logic [W-9:0]  asm_r;
    logic [IW-1:0] idx_r;
    logic          tgt_r;
    logic          full1_r;
    logic          full2_r;
    logic [W-1:0]  data1_r;
    logic [W-1:0]  data2_r;
    logic [15:0]   cnt_r;

    logic          completes_s;
    logic          tgt_full_s;
    logic          tgt_ack_s;
    logic          ready_s;
    logic          accept_s;
    logic          load1_s;
    logic          load2_s;
    logic [W-1:0]  word_s;
    logic [W-9:0]  asm_next_s;

    // Final word: bytes below idx from asm, completing byte at idx, zeros above.
    function automatic logic [W-1:0] pack_word(input logic [W-9:0]  asm_v,
                                               input logic [IW-1:0] idx_v,
                                               input logic [7:0]    byte_v);
        logic [W-1:0] w;
        w = {W{1'b0}};
        for (int b = 0; b < WORD_BYTES - 1; b++) begin
            if (IW'(b) < idx_v) begin
                w[8*b +: 8] = asm_v[8*b +: 8];
            end else if (IW'(b) == idx_v) begin
                w[8*b +: 8] = byte_v;
            end else begin
                w[8*b +: 8] = 8'h00;
            end
        end
        w[W-1 -: 8] = (idx_v == IDX_LAST) ? byte_v : 8'h00;
        return w;
    endfunction

    // Handshake: only a completing byte can be held off, and only by a full, unacked target.
    always_comb begin
        tgt_full_s = 1'b0;
        tgt_ack_s  = 1'b0;
        case (tgt_r)
            SLOT1: begin
                tgt_full_s = full1_r;
                tgt_ack_s  = ack1;
            end
            SLOT2: begin
                tgt_full_s = full2_r;
                tgt_ack_s  = ack2;
            end
            default: begin
                tgt_full_s = 1'b1;
                tgt_ack_s  = 1'b0;
            end
        endcase
        completes_s = (idx_r == IDX_LAST) | in_last;
        ready_s     = ~completes_s | ~tgt_full_s | tgt_ack_s;
        accept_s    = in_valid & ready_s;
        load1_s     = accept_s & completes_s & (tgt_r == SLOT1);
        load2_s     = accept_s & completes_s & (tgt_r == SLOT2);
        word_s      = pack_word(asm_r, idx_r, in_data);
    end

    // Next assembly contents when a non-completing byte is accepted.
    always_comb begin
        asm_next_s = asm_r;
        for (int b = 0; b < WORD_BYTES - 1; b++) begin
            if (IW'(b) == idx_r) begin
                asm_next_s[8*b +: 8] = in_data;
            end else begin
                asm_next_s[8*b +: 8] = asm_r[8*b +: 8];
            end
        end
    end

    // Assembly register, byte index and slot target pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_r <= {(W-8){1'b0}};
            idx_r <= {IW{1'b0}};
            tgt_r <= SLOT1;
        end else if (accept_s) begin
            if (completes_s) begin
                asm_r <= {(W-8){1'b0}};
                idx_r <= {IW{1'b0}};
                tgt_r <= ~tgt_r;
            end else begin
                asm_r <= asm_next_s;
                idx_r <= idx_r + 1'b1;
            end
        end
    end

    // Holding slots: a load on the ack edge wins, so the store level never glitches low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full1_r <= 1'b0;
            full2_r <= 1'b0;
            data1_r <= {W{1'b0}};
            data2_r <= {W{1'b0}};
        end else begin
            if (load1_s) begin
                full1_r <= 1'b1;
                data1_r <= word_s;
            end else if (ack1) begin
                full1_r <= 1'b0;
            end
            if (load2_s) begin
                full2_r <= 1'b1;
                data2_r <= word_s;
            end else if (ack2) begin
                full2_r <= 1'b0;
            end
        end
    end

    // Emitted-word counter, free-running modulo 2^16.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 16'h0000;
        end else if (load1_s | load2_s) begin
            cnt_r <= cnt_r + 16'h0001;
        end
    end

    assign in_ready = ready_s;
    assign store1   = full1_r;
    assign store2   = full2_r;
    assign data1    = data1_r;
    assign data2    = data2_r;
    assign word_cnt = cnt_r;

endmodule

// File: doc/io_word_assembler.md
# io_word_assembler

Upstream feeder of the IO module's memory manager.
- Accepts an 8-bit byte stream from the external IO port with a valid/ready handshake.
- Packs the bytes little-endian into 32-bit words.
- Sends completed words to two single-word holding slots, alternating between them.
- Presents each held slot to the memory manager as store1/data1 and store2/data2 until the word is acknowledged.

## Interface
Parameters:
- WORD_BYTES, 4, bytes per assembled word; data width is 8*WORD_BYTES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  a byte is offered on in_data.
- in_data  in  8  byte payload.
- in_last  in  1  qualifies the current byte as the final byte of a message; the partial word is zero-padded and emitted.
- in_ready  out  1  the block accepts the byte this cycle; transfer occurs when in_valid & in_ready.
- ack1  in  1  one-cycle pulse: downstream has consumed slot 1.
- ack2  in  1  one-cycle pulse: downstream has consumed slot 2.
- store1  out  1  slot 1 holds a valid word (level).
- store2  out  1  slot 2 holds a valid word (level).
- data1  out  32  slot 1 word; stable while store1 is high.
- data2  out  32  slot 2 word; stable while store2 is high.
- word_cnt  out  16  number of words emitted since reset; wraps from 0xFFFF to 0.

## Operation
- Assembly register asm[23:0] and byte index idx (0..3).
- Each accepted byte with idx<3 and in_last=0 is written to asm[8*idx +: 8], then idx increments.
- Completion condition: an accepted byte with idx==3, or an accepted byte with in_last=1.
- On completion:
  - word = {accepted byte, asm} with every byte position above idx forced to 0.
  - The word loads into the target slot; the slot's full flag sets.
  - idx and asm clear.
  - tgt toggles (0→1→0…).
  - word_cnt increments.
- Target pointer tgt starts at slot 1 and strictly alternates. A free opposite slot is never used out of order.
- in_ready rules:
  - Always 1 when the accepted byte would not complete a word.
  - For a completing byte: 1 only if the target slot is empty, or its ack arrives in the same cycle.
  - in_ready is combinational from the full flags, ack, idx and in_last.
- Ack handling:
  - ackN clears slot N's full flag.
  - Simultaneous ackN and load into slot N: the slot stays full with the new word, and no cycle with storeN=0 occurs.
  - An ack to an empty slot is ignored.
- Stall: while in_ready=0, asm, idx and tgt hold, and the offered byte is not consumed.
- Reset (async, at any time, including mid-word or mid-stall):
  - store1=store2=0, data1=data2=0, word_cnt=0.
  - idx=0, asm=0, tgt=slot 1.
  - in_ready=1 once reset deasserts.
  - A partial word in progress is discarded.

## Timing
- Latency: completing byte accepted at edge k → storeN=1 and dataN valid immediately after edge k. That is one cycle of latency, registered outputs.
- Throughput: one byte per cycle with no backpressure. A word every 4 cycles, or earlier with in_last.
- storeN stays high until the edge on which ackN is sampled. It falls after that edge unless a reload occurs on the same edge.
- dataN changes only on a load into slot N.
- word_cnt updates on the same edge as the slot load.

## Test plan
- Word to slot 1: reset, then send bytes 0x11,0x22,0x33,0x44 on consecutive cycles → after the 4th edge, store1=1, data1=0x44332211, store2=0, word_cnt=1.
- Alternation: send 0xAA,0xBB,0xCC,0xDD, then 0x01,0x02,0x03,0x04 with ack1 after the first word → data1=0xDDCCBBAA, data2=0x04030201, store2=1, word_cnt=2.
- Backpressure: fill both slots with no acks, then offer a third word → first 3 bytes are accepted; in_ready=0 on the 4th byte; asm holds. Pulse ack1 → byte accepted that cycle, data1=new word, store1 never drops to 0.
- Short message: bytes 0xAB, then 0xCD with in_last=1 → data1=0x0000CDAB, idx returns to 0, next word targets slot 2.
- Reset mid-word: send 0x55,0x66, assert reset for 1 cycle, then send 0x11,0x22,0x33,0x44 → data1=0x44332211, word_cnt=1, and no trace of 0x55/0x66.
- Edge cases: ack2 while slot 2 empty → no state change. Force word_cnt to 0xFFFF (65535 words) and emit one more word → word_cnt=0.
